// File: rtl/asip_control_unit.sv
`default_nettype none
// ------------------------------------------------------------------------------
// asip_control_unit: multi-cycle FSM that sequences fetch, register file, ALU and
// framebuffer. Optional B/BNE branches when ASIP_BRANCH_EN is defined. Rev 1.0
// ------------------------------------------------------------------------------
module asip_control_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PC_W       = 32,
  parameter int PC_STEP    = 4,
  parameter int COLOR_BITS = 3,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter logic [COLOR_BITS-1:0] RESET_COLOR = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [PC_W-1:0]       PC_Get,
  input  logic [31:0]           Instruction,
  output logic [REG_ADDR_W-1:0] readRegister,
  input  logic [DATA_W-1:0]     readValue,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0]     writeValue,
  output logic                  regWriteEnable,
  output logic [3:0]            Control,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  input  logic [DATA_W-1:0]     Result,
  input  logic [3:0]            Flags,
  output logic [X_W-1:0]        XWrite,
  output logic [Y_W-1:0]        YWrite,
  output logic [COLOR_BITS-1:0] writeValueMemory,
  output logic                  memWriteEnable,
  output logic                  busy
);

  localparam logic [3:0] OP_MOV  = 4'b0000;
  localparam logic [3:0] OP_SUBS = 4'b0001;
  localparam logic [3:0] OP_ADDS = 4'b0100;
  localparam logic [3:0] OP_COL  = 4'b1000;
  localparam logic [3:0] OP_PLOT = 4'b1001;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RD_A   = 3'd2,
    S_RD_B   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_PLOT   = 3'd6
  } state_t;

  state_t                  state, state_next;
  logic [PC_W-1:0]         pc;
  logic [31:0]             ir;
  logic [DATA_W-1:0]       op1, op2, a_hold, b_hold;
  logic [3:0]              ctrl_hold, flag_reg;
  logic [COLOR_BITS-1:0]   color;
  logic [3:0]              op;
  logic                    is_alu, imm_sel;
  logic [3:0]              alu_ctrl;
  logic [DATA_W-1:0]       imm;
  logic [REG_ADDR_W-1:0]   rd, rn, rm;
  logic                    unused_bits;

  assign op       = ir[31:28];
  assign rd       = REG_ADDR_W'(ir[27:24]);
  assign rn       = REG_ADDR_W'(ir[23:20]);
  assign rm       = REG_ADDR_W'(ir[19:16]);
  assign imm      = DATA_W'(ir[15:4]);
  assign imm_sel  = ir[0];
  assign is_alu   = (op == OP_SUBS) || (op == OP_ADDS);
  assign alu_ctrl = (op == OP_SUBS) ? 4'b0010 : 4'b0100;

  // ALU operands are live only in EXEC and otherwise show the last values used
  assign A       = (state == S_EXEC) ? op1 : a_hold;
  assign B       = (state == S_EXEC) ? op2 : b_hold;
  assign Control = (state == S_EXEC) ? alu_ctrl : ctrl_hold;
  assign PC_Get  = pc;
  assign busy    = (state != S_FETCH);
  assign unused_bits = ^{ir[3:1], flag_reg};

`ifdef ASIP_BRANCH_EN
  localparam logic [3:0] OP_B   = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  logic [PC_W-1:0] br_off;
  assign br_off = PC_W'($signed(ir[27:0])) * STEP;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (run) state_next = S_DECODE;
      S_DECODE: begin
        if (op == OP_MOV || is_alu) state_next = S_RD_A;
        else if (op == OP_PLOT)     state_next = S_PLOT;
        else                        state_next = S_FETCH;
      end
      S_RD_A: begin
        if (op == OP_MOV) state_next = S_WB;
        else if (imm_sel) state_next = S_EXEC;
        else              state_next = S_RD_B;
      end
      S_RD_B:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0; ir <= '0; op1 <= '0; op2 <= '0; flag_reg <= '0;
      color <= RESET_COLOR; a_hold <= '0; b_hold <= '0; ctrl_hold <= '0;
      readRegister <= '0; writeRegister <= '0; writeValue <= '0;
      regWriteEnable <= 1'b0; memWriteEnable <= 1'b0;
      XWrite <= '0; YWrite <= '0; writeValueMemory <= '0;
    end else begin
      regWriteEnable <= 1'b0;
      memWriteEnable <= 1'b0;
      case (state)
        S_FETCH: if (run) ir <= Instruction;
        S_DECODE: begin
          if (op == OP_MOV || is_alu) begin
            readRegister <= rn;
          end else if (op == OP_COL) begin
            color <= COLOR_BITS'(ir[27:25]);
            pc    <= pc + STEP;
          end else if (op == OP_PLOT) begin
            XWrite           <= X_W'(ir[27:19]);
            YWrite           <= Y_W'(ir[18:11]);
            writeValueMemory <= color;
            memWriteEnable   <= 1'b1;
`ifdef ASIP_BRANCH_EN
          end else if (op == OP_B) begin
            pc <= pc + br_off;
          end else if (op == OP_BNE) begin
            pc <= flag_reg[2] ? pc + STEP : pc + br_off;
`endif
          end else begin
            pc <= pc + STEP;
          end
        end
        S_RD_A: begin
          op1 <= readValue;
          if (op == OP_MOV) begin
            writeRegister  <= rd;
            writeValue     <= readValue;
            regWriteEnable <= 1'b1;
          end else if (imm_sel) begin
            op2 <= imm;
          end else begin
            readRegister <= rm;
          end
        end
        S_RD_B: op2 <= readValue;
        S_EXEC: begin
          a_hold         <= op1;
          b_hold         <= op2;
          ctrl_hold      <= alu_ctrl;
          writeValue     <= Result;
          flag_reg       <= Flags;
          writeRegister  <= rd;
          regWriteEnable <= 1'b1;
        end
        S_WB:    pc <= pc + STEP;
        S_PLOT:  pc <= pc + STEP;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_asip_control_unit.sv
`default_nettype none
// tb_asip_control_unit: instruction-level model predicts per-cycle strobes, operands
// and PC; directed programs pin literal results, then random programs run.
module tb_asip_control_unit;
  logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic [31:0] PC_Get, Instruction, readValue, writeValue, A, B, Result;
  logic [3:0]  readRegister, writeRegister, Control, Flags;
  logic        regWriteEnable, memWriteEnable, busy;
  logic [8:0]  XWrite;
  logic [7:0]  YWrite;
  logic [2:0]  writeValueMemory;

  logic [31:0] imem [64];
  logic [31:0] env_regs [16];
  logic [31:0] m_regs [16];
  int n_vec = 0, n_bad = 0;
  logic rst_q = 1'b1;

  asip_control_unit dut (
    .clk(clk), .reset(reset), .run(run), .PC_Get(PC_Get), .Instruction(Instruction),
    .readRegister(readRegister), .readValue(readValue), .writeRegister(writeRegister),
    .writeValue(writeValue), .regWriteEnable(regWriteEnable), .Control(Control),
    .A(A), .B(B), .Result(Result), .Flags(Flags), .XWrite(XWrite), .YWrite(YWrite),
    .writeValueMemory(writeValueMemory), .memWriteEnable(memWriteEnable), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;

  // returns {N,Z,C,V,result}
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [32:0] wide;
    logic [31:0] r;
    logic cy, v;
    if (c == 4'b0010) begin
      wide = {1'b0, a} - {1'b0, b}; r = wide[31:0]; cy = ~wide[32];
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; cy = wide[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end
    return {r[31], (r == 32'd0), cy, v, r};
  endfunction

  assign Instruction = imem[PC_Get[7:2]];
  assign readValue   = env_regs[readRegister];
  assign {Flags, Result} = alu(A, B, Control);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    env_regs[i] = v;
    m_regs[i]   = v;
  endtask

  // model state
  logic [31:0] m_pc, npc, w_cur, e_a, e_b, e_val;
  logic [35:0] ar;
  logic [3:0]  e_rd, e_ctrl;
  logic [2:0]  m_color, e_col, new_col;
  logic [8:0]  e_x;
  logic [7:0]  e_y;
  logic        m_z, e_z, set_z, set_col, active = 1'b0;
  int          j, L, exec_j, wb_j, plot_j;
  logic [31:0] obs_a, obs_b;
  logic [3:0]  obs_ctrl;
  logic [8:0]  obs_x;
  logic [7:0]  obs_y;
  logic [2:0]  obs_col;

  always @(negedge clk) begin
    if (regWriteEnable) env_regs[writeRegister] = writeValue;
    if (rst_q) begin
      chk("reset_pc_strobes", {PC_Get, busy, regWriteEnable, memWriteEnable}, 64'd0);
      chk("reset_wr_rd", {writeValue, writeRegister, readRegister}, 64'd0);
      chk("reset_ab", {A, B}, 64'd0);
      chk("reset_misc", {Control, XWrite, YWrite, writeValueMemory}, 64'd0);
      m_pc = 0; m_color = 3'b101; m_z = 1'b0; active = 1'b0;
    end else if (active) begin
      j++;
      if (j < L) begin
        chk("busy_pc", {busy, PC_Get}, {1'b1, m_pc});
        chk("strobes", {regWriteEnable, memWriteEnable}, {(j == wb_j), (j == plot_j)});
        if (j == exec_j) begin
          chk("exec_ctrl_a", {Control, A}, {e_ctrl, e_a});
          chk("exec_b", B, e_b);
          obs_a = A; obs_b = B; obs_ctrl = Control;
        end
        if (j == wb_j) begin
          chk("wb", {writeRegister, writeValue}, {e_rd, e_val});
          m_regs[e_rd] = e_val;
          if (set_z) m_z = e_z;
        end
        if (j == plot_j) begin
          chk("plot", {XWrite, YWrite, writeValueMemory}, {e_x, e_y, e_col});
          obs_x = XWrite; obs_y = YWrite; obs_col = writeValueMemory;
        end
      end else begin
        m_pc = npc;
        if (set_col) m_color = new_col;
        active = 1'b0;
      end
    end
    if (!active) begin
      chk("idle", {busy, regWriteEnable, memWriteEnable, PC_Get}, {3'b000, m_pc});
      if (run) begin
        w_cur = imem[m_pc[7:2]];
        L = 2; exec_j = -1; wb_j = -1; plot_j = -1; j = 0;
        npc = m_pc + 32'd4; set_z = 1'b0; set_col = 1'b0;
        e_rd = w_cur[27:24];
        case (w_cur[31:28])
          4'h0: begin L = 4; wb_j = 3; e_val = m_regs[w_cur[23:20]]; end
          4'h1, 4'h4: begin
            e_a    = m_regs[w_cur[23:20]];
            e_b    = w_cur[0] ? {20'd0, w_cur[15:4]} : m_regs[w_cur[19:16]];
            e_ctrl = (w_cur[31:28] == 4'h1) ? 4'b0010 : 4'b0100;
            ar     = alu(e_a, e_b, e_ctrl);
            e_val  = ar[31:0]; e_z = ar[34]; set_z = 1'b1;
            L = w_cur[0] ? 5 : 6; exec_j = L - 2; wb_j = L - 1;
          end
          4'h8: begin set_col = 1'b1; new_col = w_cur[27:25]; end
          4'h9: begin L = 3; plot_j = 2; e_x = w_cur[27:19]; e_y = w_cur[18:11]; e_col = m_color; end
`ifdef ASIP_BRANCH_EN
          4'hA: npc = m_pc + ({{4{w_cur[27]}}, w_cur[27:0]} << 2);
          4'hB: if (!m_z) npc = m_pc + ({{4{w_cur[27]}}, w_cur[27:0]} << 2);
`endif
          default: ;
        endcase
        active = 1'b1;
      end
    end
  end

  task automatic step_one(output int cycles);
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    cycles = 1;
    while (cycles < 20) begin
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
      cycles++;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:28] = 4'h0;
      1: w[31:28] = 4'h1;
      2: w[31:28] = 4'h4;
      3: w[31:28] = 4'h8;
      4: w[31:28] = 4'h9;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < 64; i++) imem[i] = 32'h7000_0000;
    for (int i = 0; i < 16; i++) set_reg(i, 32'd0);
    imem[0] = 32'h0130_0000;  // MOV R1,R3
    imem[1] = 32'h1123_0000;  // SUBS R1,R2,R3
    imem[2] = 32'h4440_FFF1;  // ADDS R4,R4,#0xFFF
    imem[3] = 32'h8600_0000;  // COL #3
    imem[4] = 32'h9321_9000;  // PLOT 100,50
    imem[5] = 32'h1523_0000;  // SUBS R5,R2,R3
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pc_busy", {PC_Get, busy}, {32'd0, 1'b0});
    chk("rst_strobes", {regWriteEnable, memWriteEnable}, 2'b00);

    set_reg(3, 32'h55);
    step_one(c);
    chk("mov_cycles", c, 4);
    chk("mov_r1", env_regs[1], 32'h55);
    chk("mov_pc", PC_Get, 32'd4);

    set_reg(2, 32'd7); set_reg(3, 32'd7);
    step_one(c);
    chk("subs_cycles", c, 6);
    chk("subs_r1", env_regs[1], 32'd0);
    chk("subs_ctrl", obs_ctrl, 4'b0010);
    chk("subs_ab", {obs_a, obs_b}, {32'd7, 32'd7});

    set_reg(4, 32'd1);
    step_one(c);
    chk("adds_cycles", c, 5);
    chk("adds_r4", env_regs[4], 32'h1000);
    chk("adds_b", obs_b, 32'hFFF);

    step_one(c);
    chk("col_cycles", c, 2);
    step_one(c);
    chk("plot_cycles", c, 3);
    chk("plot_vals", {obs_x, obs_y, obs_col}, {9'd100, 8'd50, 3'd3});

    repeat (5) @(posedge clk);
    #1;
    chk("hold_pc", {busy, PC_Get}, {1'b0, 32'd20});

    set_reg(5, 32'h1234);
    run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_r5", env_regs[5], 32'h1234);
    chk("abort_pc", PC_Get, 32'd0);

`ifdef ASIP_BRANCH_EN
    imem[0] = 32'h1660_0011;  // SUBS R6,R6,#1
    imem[1] = 32'h0760_0000;  // MOV R7,R6
    imem[2] = 32'hBFFF_FFFE;  // BNE -2
    set_reg(6, 32'd3); set_reg(7, 32'hFF);
    for (int k = 0; k < 9; k++) step_one(c);
    chk("bne_r6_r7", {env_regs[6], env_regs[7]}, 64'd0);
    chk("bne_exit_pc", PC_Get, 32'd12);
`endif

    for (int i = 0; i < 64; i++) imem[i] = rand_instr();
    for (int i = 0; i < 16; i++) set_reg(i, $urandom);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      run   = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    run = 1'b0; reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk("final_regs", env_regs[i], m_regs[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
